// File: rtl/fpga_mem_responder.sv
// fpga_mem_responder
// Memory-side endpoint of the controller<->memory burst link. Accepts 4-beat
// (32-byte) line reads and writes and services them from an internal 64-bit
// synchronous RAM. Read data and write acknowledgements go back on the
// memory->controller bus. Outputs are registered, so a read shows its first
// beat two cycles after the address beat. A write acknowledge appears one
// cycle after the final data beat.
//
// Optional build macro: FPGA_MEM_PROTO_CHECK_EN
//   defined   -> protocol-violation detection drives the sticky proto_err flag
//   undefined -> proto_err is tied low and no detection logic is built
// Violating beats are ignored in both builds.
module fpga_mem_responder #(
   parameter int unsigned MEM_WORDS_LOG2 = 10,
   parameter int unsigned BURST_LEN      = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] address_data_bus_c_to_m,
   input  logic        address_on_c_to_m,
   input  logic        data_on_c_to_m,
   input  logic        read_en_c_to_m,
   input  logic        write_en_c_to_m,
   output logic [63:0] address_data_bus_m_to_c,
   output logic        resp_m_to_c,
   output logic        proto_err
);

   localparam int unsigned DEPTH     = 1 << MEM_WORDS_LOG2;
   localparam logic [1:0]  LAST_BEAT = 2'(BURST_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_WAIT,
      S_RD_DATA,
      S_WR_DATA,
      S_WR_RESP
   } state_e;

   state_e                    state_q, state_d;
   logic [MEM_WORDS_LOG2-1:0] base_q, base_d;
   logic [1:0]                cnt_q, cnt_d;
   logic                      resp_q, resp_d;
   logic [63:0]               bus_q, bus_d;

   logic [63:0]               mem [0:DEPTH-1];
   logic [63:0]               ram_q;
   logic                      mem_we;
   logic [MEM_WORDS_LOG2-1:0] ram_wr_addr;
   logic [MEM_WORDS_LOG2-1:0] ram_rd_addr;

   logic                      addr_beat;
   logic                      data_beat;
   logic [MEM_WORDS_LOG2-1:0] line_base;
   logic                      unused_bus_bits;

   // A beat that raises both address_on and data_on is a violation.
   // It counts as neither an address beat nor a data beat.
   assign addr_beat = address_on_c_to_m & ~data_on_c_to_m;
   assign data_beat = data_on_c_to_m & ~address_on_c_to_m;

   // Word index of beat 0: addr[W+2:3] with the two beat bits cleared.
   // Higher address bits wrap modulo the RAM depth.
   assign line_base = address_data_bus_c_to_m[MEM_WORDS_LOG2+2:3] & ~MEM_WORDS_LOG2'(3);

   assign unused_bus_bits = ^{address_data_bus_c_to_m[63:MEM_WORDS_LOG2+3],
                              address_data_bus_c_to_m[2:0]};

   // The read address follows the next beat count. RAM output is then ready
   // the cycle the output register needs it: base+0 is fetched in RD_WAIT, and
   // base+k+1 is fetched while beat k is sent.
   assign ram_rd_addr = base_q + MEM_WORDS_LOG2'(cnt_d);
   assign ram_wr_addr = base_q + MEM_WORDS_LOG2'(cnt_q);

   // Next-state, beat counter and write-enable decode
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      cnt_d   = cnt_q;
      mem_we  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (addr_beat && read_en_c_to_m && !write_en_c_to_m) begin
               base_d  = line_base;
               cnt_d   = '0;
               state_d = S_RD_WAIT;
            end else if (addr_beat && write_en_c_to_m && !read_en_c_to_m) begin
               base_d  = line_base;
               cnt_d   = '0;
               state_d = S_WR_DATA;
            end
         end
         S_RD_WAIT: begin
            state_d = S_RD_DATA;
         end
         S_RD_DATA: begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == LAST_BEAT) begin
               state_d = S_IDLE;
            end
         end
         S_WR_DATA: begin
            if (data_beat) begin
               mem_we = 1'b1;
               cnt_d  = cnt_q + 2'd1;
               if (cnt_q == LAST_BEAT) begin
                  state_d = S_WR_RESP;
               end
            end
         end
         S_WR_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Registered response: data during read beats, zero bus on the write ack
   always_comb begin
      resp_d = (state_q == S_RD_DATA) || (state_q == S_WR_RESP);
      bus_d  = (state_q == S_RD_DATA) ? ram_q : '0;
   end

   // FSM, line base, beat counter and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         base_q  <= '0;
         cnt_q   <= '0;
         resp_q  <= 1'b0;
         bus_q   <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         cnt_q   <= cnt_d;
         resp_q  <= resp_d;
         bus_q   <= bus_d;
      end
   end

   // On-chip RAM: synchronous write and read, contents not reset
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[ram_wr_addr] <= address_data_bus_c_to_m;
      end
      ram_q <= mem[ram_rd_addr];
   end

   assign address_data_bus_m_to_c = bus_q;
   assign resp_m_to_c             = resp_q;

`ifdef FPGA_MEM_PROTO_CHECK_EN
   logic proto_err_q;
   logic viol;

   // Violation decode: illegal beats for the current state, or malformed beats
   always_comb begin
      viol = (address_on_c_to_m && data_on_c_to_m)
           || (address_on_c_to_m && (state_q != S_IDLE))
           || (data_on_c_to_m && (state_q != S_WR_DATA))
           || (address_on_c_to_m && (state_q == S_IDLE)
               && (read_en_c_to_m == write_en_c_to_m));
   end

   // Sticky error flag, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         proto_err_q <= 1'b0;
      end else if (viol) begin
         proto_err_q <= 1'b1;
      end
   end

   assign proto_err = proto_err_q;
`else
   assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_mem_responder.sv
// Self-checking bench for fpga_mem_responder.
// A directed vector table covers the basic line write/read, alias and
// back-to-back cases. Hand-written sequences cover protocol violations and
// asynchronous reset. Randomized bursts are checked against a word-array
// reference model.
module tb_fpga_mem_responder;

   localparam int unsigned LOG2  = 10;
   localparam int unsigned WORDS = 1 << LOG2;
   localparam int unsigned LINES = WORDS / 4;

`ifdef FPGA_MEM_PROTO_CHECK_EN
   localparam logic [63:0] PERR_EXP = 64'd1;
`else
   localparam logic [63:0] PERR_EXP = 64'd0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [63:0] bus_c2m = '0;
   logic        addr_on = 1'b0;
   logic        data_on = 1'b0;
   logic        rd_en = 1'b0;
   logic        wr_en = 1'b0;
   logic [63:0] bus_m2c;
   logic        resp;
   logic        perr;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   logic [63:0] model [0:WORDS-1];
   int unsigned written_lines [$];

   typedef struct {
      bit               wr;
      logic [31:0]      addr;
      int unsigned      gap;
      logic [3:0][63:0] d;
   } vec_t;

   vec_t tbl [10];

   fpga_mem_responder #(
      .MEM_WORDS_LOG2(LOG2),
      .BURST_LEN(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .address_data_bus_c_to_m(bus_c2m),
      .address_on_c_to_m(addr_on),
      .data_on_c_to_m(data_on),
      .read_en_c_to_m(rd_en),
      .write_en_c_to_m(wr_en),
      .address_data_bus_m_to_c(bus_m2c),
      .resp_m_to_c(resp),
      .proto_err(perr)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   function automatic vec_t mk(input bit wr, input logic [31:0] a, input int unsigned g,
                               input logic [63:0] d0, input logic [63:0] d1,
                               input logic [63:0] d2, input logic [63:0] d3);
      vec_t v;
      v.wr   = wr;
      v.addr = a;
      v.gap  = g;
      v.d    = {d3, d2, d1, d0};
      return v;
   endfunction

   // Reference address mapping: 32-byte lines, depth-modulo wrap, beat k -> word k of line.
   function automatic int unsigned word_idx(input logic [31:0] a, input int unsigned k);
      return ((int'(a) >> 5) % LINES) * 4 + k;
   endfunction

   function automatic logic [3:0][63:0] model_line(input logic [31:0] a);
      logic [3:0][63:0] r;
      for (int unsigned k = 0; k < 4; k++) r[k] = model[word_idx(a, k)];
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [3:0][63:0] d,
                           input int unsigned gap, input string tag);
      bus_c2m = {$urandom, addr};
      addr_on = 1'b1;
      wr_en   = 1'b1;
      tick();
      addr_on = 1'b0;
      wr_en   = 1'b0;
      bus_c2m = '0;
      chk({tag, "_acc_resp"}, 64'(resp), 64'd0);
      for (int k = 0; k < 4; k++) begin
         for (int unsigned g = 0; g < gap; g++) begin
            bus_c2m = {$urandom, $urandom};
            tick();
            chk({tag, "_gap_resp"}, 64'(resp), 64'd0);
         end
         data_on = 1'b1;
         bus_c2m = d[k];
         tick();
         data_on = 1'b0;
         bus_c2m = '0;
         chk($sformatf("%s_beat%0d_resp", tag, k), 64'(resp), 64'd0);
      end
      tick();
      chk({tag, "_wresp"}, 64'(resp), 64'd1);
      chk({tag, "_wresp_bus"}, bus_m2c, 64'd0);
      tick();
      chk({tag, "_wresp_end"}, 64'(resp), 64'd0);
      for (int unsigned k = 0; k < 4; k++) model[word_idx(addr, k)] = d[k];
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [3:0][63:0] e,
                          input bit inject, input string tag);
      bus_c2m = {$urandom, addr};
      addr_on = 1'b1;
      rd_en   = 1'b1;
      tick();
      addr_on = 1'b0;
      rd_en   = 1'b0;
      bus_c2m = '0;
      chk({tag, "_lat0_resp"}, 64'(resp), 64'd0);
      tick();
      chk({tag, "_lat1_resp"}, 64'(resp), 64'd0);
      for (int k = 0; k < 4; k++) begin
         tick();
         if (k == 1) begin
            addr_on = 1'b0;
            wr_en   = 1'b0;
            bus_c2m = '0;
         end
         chk($sformatf("%s_b%0d_resp", tag, k), 64'(resp), 64'd1);
         chk($sformatf("%s_b%0d_data", tag, k), bus_m2c, e[k]);
         if (k == 0 && inject) begin
            addr_on = 1'b1;
            wr_en   = 1'b1;
            bus_c2m = {32'h0, 32'h0000_0080};
         end
      end
      tick();
      chk({tag, "_end_resp"}, 64'(resp), 64'd0);
      chk({tag, "_end_bus"}, bus_m2c, 64'd0);
   endtask

   initial begin
      tbl[0] = mk(1'b1, 32'h0000_0040, 0, 64'h11, 64'h22, 64'h33, 64'h44);
      tbl[1] = mk(1'b0, 32'h0000_0040, 0, 64'h11, 64'h22, 64'h33, 64'h44);
      tbl[2] = mk(1'b1, 32'h0000_0080, 2, 64'hA1A1_0000_0000_00A1, 64'hA2A2_1111_2222_00A2,
                  64'hA3A3_3333_4444_00A3, 64'hA4A4_5555_6666_00A4);
      tbl[3] = mk(1'b0, 32'h0000_0080, 0, 64'hA1A1_0000_0000_00A1, 64'hA2A2_1111_2222_00A2,
                  64'hA3A3_3333_4444_00A3, 64'hA4A4_5555_6666_00A4);
      tbl[4] = mk(1'b0, 32'h0000_005F, 0, 64'h11, 64'h22, 64'h33, 64'h44);
      tbl[5] = mk(1'b0, 32'h0000_2040, 0, 64'h11, 64'h22, 64'h33, 64'h44);
      tbl[6] = mk(1'b1, 32'h0000_0100, 0, 64'hC1C1_C1C1_0000_0001, 64'hC2C2_C2C2_0000_0002,
                  64'hC3C3_C3C3_0000_0003, 64'hC4C4_C4C4_0000_0004);
      tbl[7] = mk(1'b0, 32'h0000_0100, 0, 64'hC1C1_C1C1_0000_0001, 64'hC2C2_C2C2_0000_0002,
                  64'hC3C3_C3C3_0000_0003, 64'hC4C4_C4C4_0000_0004);
      tbl[8] = mk(1'b1, 32'h0000_0120, 0, 64'hE1E1_0000_FFFF_0001, 64'hE2E2_0000_FFFF_0002,
                  64'hE3E3_0000_FFFF_0003, 64'hE4E4_0000_FFFF_0004);
      tbl[9] = mk(1'b0, 32'h0000_0120, 0, 64'hE1E1_0000_FFFF_0001, 64'hE2E2_0000_FFFF_0002,
                  64'hE3E3_0000_FFFF_0003, 64'hE4E4_0000_FFFF_0004);

      // Reset state
      #2 rst = 1'b1;
      #1;
      chk("rst_resp", 64'(resp), 64'd0);
      chk("rst_bus", bus_m2c, 64'd0);
      chk("rst_perr", 64'(perr), 64'd0);
      tick();
      tick();
      #2 rst = 1'b0;
      tick();
      chk("post_rst_resp", 64'(resp), 64'd0);

      // Directed vector table at minimum spacing
      for (int i = 0; i < 10; i++) begin
         if (tbl[i].wr) begin
            do_write(tbl[i].addr, tbl[i].d, tbl[i].gap, $sformatf("vec%0d_wr", i));
            written_lines.push_back(word_idx(tbl[i].addr, 0) / 4);
         end else begin
            do_read(tbl[i].addr, tbl[i].d, 1'b0, $sformatf("vec%0d_rd", i));
         end
      end
      chk("perr_clean", 64'(perr), 64'd0);

      // Protocol violations: both enables, data in IDLE, no enables, addr+data together
      bus_c2m = {$urandom, 32'h0000_0040};
      addr_on = 1'b1;
      rd_en   = 1'b1;
      wr_en   = 1'b1;
      tick();
      addr_on = 1'b0;
      rd_en   = 1'b0;
      wr_en   = 1'b0;
      chk("viol_both_en_resp", 64'(resp), 64'd0);
      chk("viol_both_en_perr", 64'(perr), PERR_EXP);
      data_on = 1'b1;
      bus_c2m = {$urandom, $urandom};
      tick();
      data_on = 1'b0;
      chk("viol_idle_data_resp", 64'(resp), 64'd0);
      addr_on = 1'b1;
      bus_c2m = {32'h0, 32'h0000_0080};
      tick();
      addr_on = 1'b0;
      chk("viol_no_en_resp", 64'(resp), 64'd0);
      addr_on = 1'b1;
      data_on = 1'b1;
      wr_en   = 1'b1;
      bus_c2m = {32'h0, 32'h0000_0100};
      tick();
      addr_on = 1'b0;
      data_on = 1'b0;
      wr_en   = 1'b0;
      bus_c2m = '0;
      chk("viol_addr_data_resp", 64'(resp), 64'd0);
      tick();
      chk("viol_settle_resp", 64'(resp), 64'd0);
      do_read(32'h0000_0040, tbl[0].d, 1'b1, "viol_inflight_rd");
      chk("viol_sticky_perr", 64'(perr), PERR_EXP);
      do_read(32'h0000_0080, model_line(32'h0000_0080), 1'b0, "viol_ram_80");
      do_read(32'h0000_0100, model_line(32'h0000_0100), 1'b0, "viol_ram_100");
      chk("viol_sticky_perr2", 64'(perr), PERR_EXP);

      // Asynchronous reset in the middle of a read burst
      bus_c2m = {$urandom, 32'h0000_0040};
      addr_on = 1'b1;
      rd_en   = 1'b1;
      tick();
      addr_on = 1'b0;
      rd_en   = 1'b0;
      bus_c2m = '0;
      tick();
      tick();
      chk("rstrd_b0_data", bus_m2c, 64'h11);
      tick();
      chk("rstrd_b1_resp", 64'(resp), 64'd1);
      chk("rstrd_b1_data", bus_m2c, 64'h22);
      #2 rst = 1'b1;
      #1;
      chk("rstrd_async_resp", 64'(resp), 64'd0);
      chk("rstrd_async_bus", bus_m2c, 64'd0);
      chk("rstrd_async_perr", 64'(perr), 64'd0);
      #2 rst = 1'b0;
      tick();
      chk("rstrd_after_resp", 64'(resp), 64'd0);
      chk("rstrd_after_bus", bus_m2c, 64'd0);

      // Asynchronous reset after the second beat of a write burst
      bus_c2m = {$urandom, 32'h0000_0080};
      addr_on = 1'b1;
      wr_en   = 1'b1;
      tick();
      addr_on = 1'b0;
      wr_en   = 1'b0;
      data_on = 1'b1;
      bus_c2m = 64'hB1B1_B1B1_0000_00B1;
      tick();
      bus_c2m = 64'hB2B2_B2B2_0000_00B2;
      tick();
      data_on = 1'b0;
      bus_c2m = '0;
      #2 rst = 1'b1;
      #1;
      chk("rstwr_async_resp", 64'(resp), 64'd0);
      chk("rstwr_async_bus", bus_m2c, 64'd0);
      #2 rst = 1'b0;
      tick();
      chk("rstwr_after_resp", 64'(resp), 64'd0);
      model[word_idx(32'h0000_0080, 0)] = 64'hB1B1_B1B1_0000_00B1;
      model[word_idx(32'h0000_0080, 1)] = 64'hB2B2_B2B2_0000_00B2;
      do_read(32'h0000_0080, model_line(32'h0000_0080), 1'b0, "rstwr_readback");
      chk("rstwr_perr", 64'(perr), 64'd0);

      // Randomized bursts against the reference model
      for (int i = 0; i < 24; i++) begin
         logic [31:0]      a;
         logic [3:0][63:0] d;
         int unsigned      line;
         if (i == 0 || $urandom_range(0, 1) == 1) begin
            line = $urandom_range(0, LINES - 1);
            a = ($urandom & 32'hFFFF_E01F) | (32'(line) << 5);
            for (int k = 0; k < 4; k++) d[k] = {$urandom, $urandom};
            do_write(a, d, $urandom_range(0, 2), $sformatf("rnd%0d_wr", i));
            written_lines.push_back(line);
         end else begin
            line = written_lines[$urandom_range(0, written_lines.size() - 1)];
            a = ($urandom & 32'hFFFF_E01F) | (32'(line) << 5);
            do_read(a, model_line(a), 1'b0, $sformatf("rnd%0d_rd", i));
         end
      end
      chk("final_perr", 64'(perr), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
